load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage of the RV32IM core, between execute and writeback.
- Takes a load/store request (address from the ALU, store data from rs2, funct3 from decode) and runs one transaction on the data-memory bus with a req/ack handshake.
- Formats load data (byte/half select, sign/zero extend) into mem_read_data, which the writeback result mux consumes.
- Raises stall for the whole access.

Parameters:
- TIMEOUT, 255, bus_ack wait limit in cycles; 0 disables the timeout.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- ld  input  1  load request (decode)
- st  input  1  store request (decode)
- funct3  input  3  access size/sign code
- addr  input  32  effective byte address (ALU_out)
- store_data  input  32  rs2 value
- stall  output  1  hold upstream pipeline
- done  output  1  one-cycle pulse: access finished
- mem_read_data  output  32  formatted load result
- misaligned  output  1  one-cycle pulse: misaligned access rejected
- bus_err  output  1  one-cycle pulse: bus timeout
- bus_req  output  1  bus request
- bus_we  output  1  1 = write
- bus_addr  output  32  word address, {addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_be  output  4  byte enables
- bus_rdata  input  32  read data
- bus_ack  input  1  transaction complete

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0. mem_read_data = 0.
- States: IDLE, WAIT, DONE.
- IDLE, ld|st asserted, access aligned:
  - latch addr, funct3, store_data and the access type; go to WAIT.
  - ld has priority when ld and st are both asserted.
- stall is combinational: (IDLE & (ld|st) & ~reject) | WAIT.
- WAIT: bus_req=1, driven from registers; bus_we, bus_addr, bus_wdata and bus_be are held stable.
  - bus_ack=1 → capture/format bus_rdata (loads only); next state DONE; bus_req drops.
  - Ack may arrive in the first WAIT cycle.
  - Minimum latency: request cycle → WAIT → DONE (done high 2 cycles after request).
- DONE: done=1 for one cycle; stall=0; next state IDLE.
  - A new request is accepted only in IDLE; requests in WAIT/DONE are ignored.
- mem_read_data holds its value until the next load completes; stores do not change it.
- Load formatting, with b = addr[1:0]:
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend half b[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend half b[1].
  - 011/110/111: treated as LW.
- Store encoding:
  - SB (000): bus_be = 1<<b; bus_wdata = byte replicated x4.
  - SH (001): bus_be = 0011 if b[1]=0, else 1100; bus_wdata = half replicated x2.
  - SW (010 and others): bus_be = 1111; bus_wdata = store_data.
  - On loads, bus_be = 1111.
- Timeout (TIMEOUT>0): a counter clears on entry to WAIT and increments each WAIT cycle without ack. At count TIMEOUT-1:
  - bus_req drops;
  - a load writes mem_read_data = 0;
  - go to DONE with done=1 and bus_err=1 in the same cycle.
- Reset mid-WAIT: bus_req drops immediately (async); no done pulse.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, is rejected.
  - misaligned=1 for one cycle in IDLE; reject=1.
  - No bus access, no stall, no done; state stays IDLE.
- Not defined: no check. Halves use addr[1] and words ignore addr[1:0]; the access is performed normally. misaligned is tied 0.

Test Plan:
- LB addr=0x1003, bus_rdata=0x80FF_1234, ack on first WAIT cycle → bus_addr=0x1000, bus_be=1111, done 2 cycles after request, mem_read_data=0xFFFF_FF80, stall high for exactly 2 cycles.
- LHU addr=0x2002, bus_rdata=0xBEEF_0000 → mem_read_data=0x0000_BEEF. LH at the same address → 0xFFFF_BEEF.
- SB addr=0x10, store_data=0x0000_00A5 → bus_we=1, bus_be=0001, bus_wdata=0xA5A5_A5A5; SH addr=0x12, store_data=0x1234 → bus_be=1100, bus_wdata=0x1234_1234. mem_read_data unchanged for both.
- ack delayed 5 cycles → stall high 6 cycles; bus outputs stable throughout; new ld during WAIT ignored.
- TIMEOUT=4, no ack → bus_req high 4 cycles, then done=1, bus_err=1, mem_read_data=0; rst_n pulsed low mid-WAIT in a second run → bus_req=0 immediately, no done.
- MISALIGN_TRAP_EN: LW addr=0x1001 → misaligned=1 one cycle, bus_req never set, stall=0. Without the macro, the same access → bus_addr=0x1000, normal completion.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 memory-access stage driving a req/ack data bus and formatting load data.
// Optional misaligned-access rejection is enabled with `define MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic        st,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] mem_read_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic        is_ld;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] cnt;
    logic        req, reject, st_byte, st_half, timed_out;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_val;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign req     = state == IDLE && (ld || st);
    assign st_byte = funct3 == 3'b000;
    assign st_half = funct3 == 3'b001;

`ifdef MISALIGN_TRAP_EN
    logic ld_byte, ld_half, half_acc, word_acc;
    assign ld_byte  = funct3[1:0] == 2'b00;
    assign ld_half  = funct3[1:0] == 2'b01;
    assign half_acc = ld ? ld_half : st_half;
    assign word_acc = ld ? !(ld_byte || ld_half) : !(st_byte || st_half);
    assign reject   = req && ((half_acc && addr[0]) || (word_acc && addr[1:0] != 2'b00));
`else
    assign reject   = 1'b0;
`endif

    assign misaligned = reject;
    assign stall      = (req && !reject) || state == WAIT;

    // Loads always fetch the full word; only stores narrow the byte enables.
    assign be_d    = ld ? 4'b1111 : st_byte ? 4'b0001 << addr[1:0] :
                     st_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_d = st_byte ? {4{store_data[7:0]}} : st_half ? {2{store_data[15:0]}} : store_data;

    assign rd_byte = off_q == 2'd0 ? bus_rdata[7:0] : off_q == 2'd1 ? bus_rdata[15:8] :
                     off_q == 2'd2 ? bus_rdata[23:16] : bus_rdata[31:24];
    assign rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign ld_val  = f3_q == 3'b000 ? {{24{rd_byte[7]}}, rd_byte} :
                     f3_q == 3'b001 ? {{16{rd_half[15]}}, rd_half} :
                     f3_q == 3'b100 ? {24'd0, rd_byte} :
                     f3_q == 3'b101 ? {16'd0, rd_half} : bus_rdata;

    assign timed_out = TIMEOUT != 0 && cnt == TIMEOUT - 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            is_ld         <= 1'b0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
            cnt           <= 32'd0;
            done          <= 1'b0;
            bus_err       <= 1'b0;
            mem_read_data <= 32'd0;
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= 32'd0;
            bus_wdata     <= 32'd0;
            bus_be        <= 4'd0;
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: if (req && !reject) begin
                    state     <= WAIT;
                    is_ld     <= ld;
                    f3_q      <= funct3;
                    off_q     <= addr[1:0];
                    cnt       <= 32'd0;
                    bus_req   <= 1'b1;
                    bus_we    <= !ld;
                    bus_addr  <= {addr[31:2], 2'b00};
                    bus_wdata <= wdata_d;
                    bus_be    <= be_d;
                end
                WAIT: if (bus_ack) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    bus_req <= 1'b0;
                    if (is_ld) mem_read_data <= ld_val;
                end else if (timed_out) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    bus_err <= 1'b1;
                    bus_req <= 1'b0;
                    if (is_ld) mem_read_data <= 32'd0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit against a byte-lane model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n, ld, st, bus_ack, ld_t, bus_ack_t;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, bus_rdata;
    logic        stall, done, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] mem_read_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        stall_t, done_t, misaligned_t, bus_err_t, bus_req_t, bus_we_t;
    logic [31:0] mem_read_data_t, bus_addr_t, bus_wdata_t;
    logic [3:0]  bus_be_t;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .ld(ld), .st(st), .funct3(funct3), .addr(addr),
        .store_data(store_data), .stall(stall), .done(done), .mem_read_data(mem_read_data),
        .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack)
    );

    load_store_unit #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .ld(ld_t), .st(1'b0), .funct3(funct3), .addr(addr),
        .store_data(store_data), .stall(stall_t), .done(done_t), .mem_read_data(mem_read_data_t),
        .misaligned(misaligned_t), .bus_err(bus_err_t), .bus_req(bus_req_t), .bus_we(bus_we_t),
        .bus_addr(bus_addr_t), .bus_wdata(bus_wdata_t), .bus_be(bus_be_t), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack_t)
    );

    // access size in bytes as decoded from funct3
    function automatic int acc_size(input logic l, input logic [2:0] f);
        if (l) return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
        return f == 3'd0 ? 1 : f == 3'd1 ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rd);
        int n = acc_size(1'b1, f);
        int sh = n == 1 ? 8 * int'(a[1:0]) : n == 2 ? 16 * int'(a[1]) : 0;
        logic [31:0] v = rd >> sh;
        if (n == 4) return rd;
        v = v & (n == 1 ? 32'hFF : 32'hFFFF);
        if (!f[2] && v[8*n-1]) v = v | (n == 1 ? 32'hFFFF_FF00 : 32'hFFFF_0000);
        return v;
    endfunction

    function automatic logic [3:0] be_model(input logic l, input logic [2:0] f, input logic [31:0] a);
        int n = acc_size(l, f);
        if (l || n == 4) return 4'hF;
        if (n == 1) return 4'h1 << a[1:0];
        return a[1] ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] f, input logic [31:0] sd);
        int n = acc_size(1'b0, f);
        return n == 1 ? sd[7:0] * 32'h0101_0101 : n == 2 ? sd[15:0] * 32'h0001_0001 : sd;
    endfunction

    // Drives one access on dut and reports what was observed; returns at the negedge of the done cycle.
    task automatic run_access(input logic l, input logic both, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input int ack_at, input logic poke,
                              output int n_stall, output int lat, output logic [31:0] o_addr,
                              output logic [3:0] o_be, output logic [31:0] o_wd, output logic o_we,
                              output logic stable);
        @(negedge clk);
        ld = l; st = !l || both; funct3 = f; addr = a; store_data = sd; bus_rdata = rd;
        #1;
        n_stall = int'(stall); lat = -1; stable = 1'b1;
        o_addr = 32'd0; o_be = 4'd0; o_wd = 32'd0; o_we = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            n_stall += int'(stall);
            if (c == 1) begin
                o_addr = bus_addr; o_be = bus_be; o_wd = bus_wdata; o_we = bus_we;
            end else if (bus_req && (bus_addr !== o_addr || bus_be !== o_be || bus_wdata !== o_wd || bus_we !== o_we))
                stable = 1'b0;
            if (done) lat = c;
            ld = 1'b0; st = 1'b0; bus_ack = 1'b0;
            if (poke && c == 2) begin ld = 1'b1; addr = a ^ 32'h40; end
            if (c == ack_at) bus_ack = 1'b1;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ld = 0; st = 0; ld_t = 0; bus_ack = 0; bus_ack_t = 0;
        funct3 = 0; addr = 0; store_data = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, done, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be} !== 73'd0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0",
                {stall, done, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be});
        end
        checks++;
        if (mem_read_data !== 32'd0 || {stall_t, done_t, misaligned_t, bus_err_t, bus_req_t, bus_we_t,
            bus_addr_t, bus_wdata_t, bus_be_t, mem_read_data_t} !== 105'd0) begin
            errors++; $display("FAIL reset_data: got %h required 0", mem_read_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lb;
        int ns, lat; logic [31:0] oa, ow; logic [3:0] ob; logic owe, stb;
        run_access(1, 0, 3'b000, 32'h1003, 0, 32'h80FF_1234, 1, 0, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (oa !== 32'h1000 || ob !== 4'hF || owe !== 1'b0) begin
            errors++; $display("FAIL lb_bus: got addr=%h be=%b we=%b required 1000/1111/0", oa, ob, owe);
        end
        checks++;
        if (lat !== 2 || ns !== 2) begin
            errors++; $display("FAIL lb_timing: got lat=%0d stall=%0d required 2/2", lat, ns);
        end
        checks++;
        if (mem_read_data !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL lb_data: got %h required ffffff80", mem_read_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done=%b stall=%b required 0/0", done, stall);
        end
    endtask

    task automatic test_lhu_lh;
        int ns, lat; logic [31:0] oa, ow; logic [3:0] ob; logic owe, stb;
        run_access(1, 0, 3'b101, 32'h2002, 0, 32'hBEEF_0000, 1, 0, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (mem_read_data !== 32'h0000_BEEF) begin
            errors++; $display("FAIL lhu_data: got %h required 0000beef", mem_read_data);
        end
        run_access(1, 1, 3'b001, 32'h2002, 32'h5555_5555, 32'hBEEF_0000, 1, 0, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (mem_read_data !== 32'hFFFF_BEEF || owe !== 1'b0) begin
            errors++; $display("FAIL lh_priority: got %h we=%b required ffffbeef/0", mem_read_data, owe);
        end
    endtask

    task automatic test_store;
        int ns, lat; logic [31:0] oa, ow; logic [3:0] ob; logic owe, stb;
        run_access(0, 0, 3'b000, 32'h10, 32'h0000_00A5, 32'h0, 1, 0, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (owe !== 1'b1 || ob !== 4'b0001 || ow !== 32'hA5A5_A5A5 || oa !== 32'h10) begin
            errors++; $display("FAIL sb_bus: got we=%b be=%b wd=%h addr=%h required 1/0001/a5a5a5a5/10", owe, ob, ow, oa);
        end
        checks++;
        if (mem_read_data !== 32'hFFFF_BEEF || lat !== 2) begin
            errors++; $display("FAIL sb_keep: got %h lat=%0d required ffffbeef/2", mem_read_data, lat);
        end
        run_access(0, 0, 3'b001, 32'h12, 32'h0000_1234, 32'h0, 1, 0, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (ob !== 4'b1100 || ow !== 32'h1234_1234 || oa !== 32'h10 || mem_read_data !== 32'hFFFF_BEEF) begin
            errors++; $display("FAIL sh_bus: got be=%b wd=%h addr=%h mrd=%h required 1100/12341234/10/ffffbeef", ob, ow, oa, mem_read_data);
        end
    endtask

    task automatic test_delayed_ack;
        int ns, lat; logic [31:0] oa, ow; logic [3:0] ob; logic owe, stb;
        run_access(1, 0, 3'b010, 32'h4000, 0, 32'hCAFE_F00D, 5, 1, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (ns !== 6 || lat !== 6) begin
            errors++; $display("FAIL delay_timing: got stall=%0d lat=%0d required 6/6", ns, lat);
        end
        checks++;
        if (stb !== 1'b1 || oa !== 32'h4000 || mem_read_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL delay_stable: got stable=%b addr=%h mrd=%h required 1/4000/cafef00d", stb, oa, mem_read_data);
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || bus_req !== 1'b0) begin
            errors++; $display("FAIL wait_ignore: got stall=%b req=%b required 0/0", stall, bus_req);
        end
    endtask

    task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        ld = 1; st = 0; funct3 = 3'b010; addr = 32'h1001; #1;
        checks++;
        if (misaligned !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL mis_flag: got mis=%b stall=%b required 1/0", misaligned, stall);
        end
        @(negedge clk);
        ld = 0;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || done !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL mis_nobus: got req=%b done=%b mis=%b required 0/0/0", bus_req, done, misaligned);
        end
`else
        int ns, lat; logic [31:0] oa, ow; logic [3:0] ob; logic owe, stb;
        run_access(1, 0, 3'b010, 32'h1001, 0, 32'h1122_3344, 1, 0, ns, lat, oa, ob, ow, owe, stb);
        checks++;
        if (oa !== 32'h1000 || lat !== 2 || mem_read_data !== 32'h1122_3344 || misaligned !== 1'b0) begin
            errors++; $display("FAIL mis_off: got addr=%h lat=%0d mrd=%h required 1000/2/11223344", oa, lat, mem_read_data);
        end
`endif
    endtask

    task automatic test_random;
        int ns, lat, n, k; logic [31:0] oa, ow, a, sd, rd, exp_mrd; logic [3:0] ob; logic owe, stb, l; logic [2:0] f;
        exp_mrd = mem_read_data === 32'h1122_3344 ? 32'h1122_3344 : 32'hCAFE_F00D;
        for (int i = 0; i < 40; i++) begin
            l = 1'($urandom_range(0, 1)); f = 3'($urandom_range(0, 7));
            a = $urandom; sd = $urandom; rd = $urandom; k = $urandom_range(1, 4);
            n = acc_size(l, f);
`ifdef MISALIGN_TRAP_EN
            a = a & ~32'(n - 1);
`endif
            run_access(l, 0, f, a, sd, rd, k, 0, ns, lat, oa, ob, ow, owe, stb);
            if (l) exp_mrd = load_model(f, a, rd);
            checks++;
            if (lat !== k + 1 || ns !== k + 1 || stb !== 1'b1) begin
                errors++; $display("FAIL rnd_timing[%0d]: got lat=%0d stall=%0d required %0d", i, lat, ns, k + 1);
            end
            checks++;
            if (oa !== {a[31:2], 2'b00} || ob !== be_model(l, f, a) || owe !== !l || (!l && ow !== wdata_model(f, sd))) begin
                errors++; $display("FAIL rnd_bus[%0d]: got addr=%h be=%b wd=%h required %h/%b/%h",
                    i, oa, ob, ow, {a[31:2], 2'b00}, be_model(l, f, a), wdata_model(f, sd));
            end
            checks++;
            if (mem_read_data !== exp_mrd) begin
                errors++; $display("FAIL rnd_data[%0d]: got %h required %h (f3=%0d a=%h)", i, mem_read_data, exp_mrd, f, a);
            end
        end
    endtask

    task automatic test_timeout;
        int nreq; logic seen_done, seen_err;
        @(negedge clk);
        ld_t = 1; funct3 = 3'b010; addr = 32'h3000; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ld_t = 0; bus_ack_t = 1;
        @(negedge clk);
        bus_ack_t = 0;
        checks++;
        if (done_t !== 1'b1 || bus_err_t !== 1'b0 || mem_read_data_t !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL to_warmup: got done=%b err=%b mrd=%h required 1/0/deadbeef", done_t, bus_err_t, mem_read_data_t);
        end
        @(negedge clk);
        ld_t = 1;
        @(negedge clk);
        ld_t = 0; nreq = 0; seen_done = 0; seen_err = 0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            nreq += int'(bus_req_t);
            if (done_t) begin seen_done = 1; seen_err = bus_err_t; end
            else @(negedge clk);
        end
        checks++;
        if (nreq !== 4 || !seen_done || !seen_err) begin
            errors++; $display("FAIL timeout: got req_cycles=%0d done=%b err=%b required 4/1/1", nreq, seen_done, seen_err);
        end
        checks++;
        if (mem_read_data_t !== 32'd0) begin
            errors++; $display("FAIL timeout_data: got %h required 0", mem_read_data_t);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic bad;
        @(negedge clk);
        @(negedge clk);
        ld_t = 1;
        @(negedge clk);
        ld_t = 0;
        @(negedge clk);
        checks++;
        if (bus_req_t !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got req=%b required 1", bus_req_t);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req_t !== 1'b0 || stall_t !== 1'b0 || done_t !== 1'b0) begin
            errors++; $display("FAIL rst_async: got req=%b stall=%b done=%b required 0/0/0", bus_req_t, stall_t, done_t);
        end
        @(negedge clk);
        rst_n = 1'b1; bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_t || bus_req_t) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL rst_nodone: got activity=%b required 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_lb;
        test_lhu_lh;
        test_store;
        test_delayed_ack;
        test_misalign;
        test_random;
        test_timeout;
        test_reset_mid_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
